// File: rtl/mem_accum_engine_if.sv
// Command/status and memory-port bundle for mem_accum_engine.
// master = requester plus memory side, slave = the engine.
interface mem_accum_engine_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 5
);
  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] dest_addr;
  logic              ready;
  logic              done;
  logic              overflow;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic              read_enable;
  logic              write_enable;
  logic [DATA_W-1:0] data_out;

  modport master (
    output start, mode, base_addr, count, dest_addr, data_out,
    input  ready, done, overflow, address, data_in, read_enable, write_enable
  );

  modport slave (
    input  start, mode, base_addr, count, dest_addr, data_out,
    output ready, done, overflow, address, data_in, read_enable, write_enable
  );
endinterface

// File: rtl/mem_accum_engine.sv
// Streams Count memory words from BaseAddr, reduces them (sum or max) and writes the result to DestAddr.
// Optional build macro SATURATE_EN: an overflowing sum is written as all ones instead of wrapping.
module mem_accum_engine #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  mem_accum_engine_if.slave  eng_if
);

  localparam int unsigned ACC_W = DATA_W + ADDR_W + 1;
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  state_e            state_q;
  logic              mode_q;
  logic [ADDR_W-1:0] dest_q;
  logic [CNT_W-1:0]  left_q;
  logic              rd_valid_q;
  logic [ACC_W-1:0]  acc_q;

  logic              ready_q;
  logic              done_q;
  logic              overflow_q;
  logic [ADDR_W-1:0] address_q;
  logic [DATA_W-1:0] data_in_q;
  logic              read_enable_q;
  logic              write_enable_q;

  logic [ACC_W-1:0]  word_c;
  logic [ACC_W-1:0]  acc_d;
  logic              ovf_d;
  logic [DATA_W-1:0] result_d;

  // Reduction step applied to the word returned by last cycle's read.
  always_comb begin
    word_c   = ACC_W'(eng_if.data_out);
    acc_d    = acc_q;
    if (rd_valid_q) begin
      if (mode_q) begin
        acc_d = (word_c > acc_q) ? word_c : acc_q;
      end else begin
        acc_d = acc_q + word_c;
      end
    end
    ovf_d    = !mode_q && (|acc_d[ACC_W-1:DATA_W]);
`ifdef SATURATE_EN
    result_d = ovf_d ? {DATA_W{1'b1}} : acc_d[DATA_W-1:0];
`else
    result_d = acc_d[DATA_W-1:0];
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      mode_q         <= 1'b0;
      dest_q         <= '0;
      left_q         <= '0;
      rd_valid_q     <= 1'b0;
      acc_q          <= '0;
      ready_q        <= 1'b1;
      done_q         <= 1'b0;
      overflow_q     <= 1'b0;
      address_q      <= '0;
      data_in_q      <= '0;
      read_enable_q  <= 1'b0;
      write_enable_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      rd_valid_q <= read_enable_q;
      if (rd_valid_q) begin
        acc_q <= acc_d;
      end

      case (state_q)
        ST_IDLE: begin
          if (eng_if.start) begin
            mode_q     <= eng_if.mode;
            dest_q     <= eng_if.dest_addr;
            left_q     <= eng_if.count;
            acc_q      <= '0;
            overflow_q <= 1'b0;
            ready_q    <= 1'b0;
            if (eng_if.count != '0) begin
              state_q       <= ST_RUN;
              read_enable_q <= 1'b1;
              address_q     <= eng_if.base_addr;
            end else begin
              // Empty reduction goes straight to writing a zero result.
              state_q        <= ST_WRITE;
              write_enable_q <= 1'b1;
              address_q      <= eng_if.dest_addr;
              data_in_q      <= '0;
            end
          end
        end

        ST_RUN: begin
          left_q <= left_q - CNT_W'(1);
          if (left_q == CNT_W'(1)) begin
            state_q       <= ST_DRAIN;
            read_enable_q <= 1'b0;
            address_q     <= '0;
          end else begin
            address_q <= address_q + ADDR_W'(1);
          end
        end

        ST_DRAIN: begin
          // Last word arrives now; acc_d already folds it in.
          state_q        <= ST_WRITE;
          write_enable_q <= 1'b1;
          address_q      <= dest_q;
          data_in_q      <= result_d;
          overflow_q     <= ovf_d;
        end

        ST_WRITE: begin
          state_q        <= ST_IDLE;
          write_enable_q <= 1'b0;
          address_q      <= '0;
          data_in_q      <= '0;
          done_q         <= 1'b1;
          ready_q        <= 1'b1;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign eng_if.ready        = ready_q;
  assign eng_if.done         = done_q;
  assign eng_if.overflow     = overflow_q;
  assign eng_if.address      = address_q;
  assign eng_if.data_in      = data_in_q;
  assign eng_if.read_enable  = read_enable_q;
  assign eng_if.write_enable = write_enable_q;

endmodule

// File: tb/tb_mem_accum_engine.sv
// Randomized self-checking bench for mem_accum_engine with a behavioural memory and reduction model.
module tb_mem_accum_engine;

  logic clk;
  logic rst;

  mem_accum_engine_if #(.DATA_W(16), .ADDR_W(5)) bus_if ();

  mem_accum_engine #(.DATA_W(16), .ADDR_W(5)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .eng_if (bus_if)
  );

  logic [15:0] mem     [32];
  int          ref_mem [32];
  logic        pre_we;
  logic [4:0]  pre_addr;
  logic [15:0] pre_data;
  int          n_checks;
  int          n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port word memory: one-cycle read latency.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus_if.write_enable) mem[bus_if.address] <= bus_if.data_in;
    if (bus_if.read_enable) bus_if.data_out <= mem[bus_if.address];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input int a, input int d);
    pre_we   = 1'b1;
    pre_addr = 5'(a);
    pre_data = 16'(d);
    ref_mem[a % 32] = d & 32'hFFFF;
    @(posedge clk); #1;
    pre_we   = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, " ready"}, 32'(bus_if.ready), 1);
    check_eq({tag, " done"}, 32'(bus_if.done), 0);
    check_eq({tag, " ovf"}, 32'(bus_if.overflow), 0);
    check_eq({tag, " addr"}, 32'(bus_if.address), 0);
    check_eq({tag, " wdata"}, 32'(bus_if.data_in), 0);
    check_eq({tag, " rd_en"}, 32'(bus_if.read_enable), 0);
    check_eq({tag, " wr_en"}, 32'(bus_if.write_enable), 0);
  endtask

  // Called in a cycle where the engine is idle; returns in the Done cycle.
  task automatic run_op(input bit m, input int base, input int n, input int dest, input bit glitch);
    int  sum, mx, w, res, total, exp_addr;
    bit  ovf, exp_re, exp_we;
    sum = 0;
    mx  = 0;
    for (int i = 0; i < n; i++) begin
      w = ref_mem[(base + i) % 32];
      sum += w;
      if (w > mx) mx = w;
    end
    ovf = !m && (sum > 65535);
    if (m) res = mx;
    else if (ovf) begin
`ifdef SATURATE_EN
      res = 65535;
`else
      res = sum & 65535;
`endif
    end else res = sum;
    total = (n == 0) ? 2 : n + 3;

    check_eq("ready_at_start", 32'(bus_if.ready), 1);
    bus_if.start     = 1'b1;
    bus_if.mode      = m;
    bus_if.base_addr = 5'(base);
    bus_if.count     = 6'(n);
    bus_if.dest_addr = 5'(dest);
    for (int c = 1; c <= total; c++) begin
      @(posedge clk); #1;
      exp_re   = (c >= 1) && (c <= n);
      exp_we   = (n == 0) ? (c == 1) : (c == n + 2);
      exp_addr = exp_re ? (base + c - 1) % 32 : (exp_we ? dest % 32 : 0);
      check_eq($sformatf("rd_en c%0d", c), 32'(bus_if.read_enable), 32'(exp_re));
      check_eq($sformatf("wr_en c%0d", c), 32'(bus_if.write_enable), 32'(exp_we));
      check_eq($sformatf("addr c%0d", c), 32'(bus_if.address), 32'(exp_addr));
      check_eq($sformatf("wdata c%0d", c), 32'(bus_if.data_in), exp_we ? 32'(res) : 0);
      check_eq($sformatf("done c%0d", c), 32'(bus_if.done), 32'(c == total));
      check_eq($sformatf("ready c%0d", c), 32'(bus_if.ready), 32'(c == total));
      if (c == total) check_eq("overflow", 32'(bus_if.overflow), 32'(ovf));
      if (c == 1 && glitch) begin
        // Start while busy with different arguments must be ignored.
        bus_if.start     = 1'b1;
        bus_if.mode      = 1'($urandom);
        bus_if.base_addr = 5'($urandom);
        bus_if.count     = 6'($urandom_range(0, 32));
        bus_if.dest_addr = 5'($urandom);
      end else if (c == 1 || c == 2) begin
        bus_if.start     = 1'b0;
        bus_if.mode      = 1'($urandom);
        bus_if.base_addr = 5'($urandom);
        bus_if.count     = 6'($urandom_range(0, 32));
        bus_if.dest_addr = 5'($urandom);
      end
    end
    ref_mem[dest % 32] = res;
  endtask

  initial begin
    n_checks         = 0;
    n_errors         = 0;
    rst              = 1'b1;
    pre_we           = 1'b0;
    pre_addr         = '0;
    pre_data         = '0;
    bus_if.start     = 1'b0;
    bus_if.mode      = 1'b0;
    bus_if.base_addr = '0;
    bus_if.count     = '0;
    bus_if.dest_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    for (int a = 0; a < 32; a++) poke(a, int'($urandom_range(0, 65535)));

    // Directed scenarios.
    poke(2, 1); poke(3, 2); poke(4, 3); poke(5, 4);
    run_op(1'b0, 2, 4, 31, 1'b0);
    poke(0, 7); poke(1, 16'hFFFE); poke(2, 3);
    run_op(1'b1, 0, 3, 8, 1'b0);
    poke(30, 16'hFFFF); poke(31, 2); poke(0, 1);
    run_op(1'b0, 30, 3, 12, 1'b0);
    run_op(1'b0, 9, 0, 4, 1'b0);
    run_op(1'b1, 17, 32, 20, 1'b0);
    run_op(1'b0, 5, 6, 21, 1'b0);
    run_op(1'b0, 7, 5, 22, 1'b1);
    run_op(1'b1, 0, 0, 23, 1'b1);

    // Random operations, with occasional big-value fills to provoke overflow.
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 3) == 0)
        for (int a = 0; a < 4; a++) poke(int'($urandom_range(0, 31)), int'($urandom_range(60000, 65535)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      run_op(1'($urandom), int'($urandom_range(0, 31)), int'($urandom_range(0, 32)),
             int'($urandom_range(0, 31)), 1'($urandom));
    end

    // Reset in the middle of a long run: no result write may follow.
    @(posedge clk); #1;
    bus_if.start     = 1'b1;
    bus_if.mode      = 1'b0;
    bus_if.base_addr = 5'd10;
    bus_if.count     = 6'd8;
    bus_if.dest_addr = 5'd25;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("mid_reset");
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      check_eq("post_reset wr_en", 32'(bus_if.write_enable), 0);
    end

    for (int a = 0; a < 32; a++) check_eq($sformatf("mem[%0d]", a), 32'(mem[a]), 32'(ref_mem[a]));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
